// File: rtl/det_pkg.sv
// Shared definitions for the determinant engine's matrix store: default
// widths, controller state encoding and read-response classification.
package det_pkg;

   localparam int DW_DEF    = 20;
   localparam int RW_DEF    = 40;
   localparam int MAX_N_DEF = 8;

   typedef enum logic [1:0] {
      ST_LOAD_N = 2'd0,
      ST_LOAD_E = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // What the store answers to an engine read in the current cycle.
   typedef enum logic [1:0] {
      RSP_ZERO = 2'd0,
      RSP_HDR  = 2'd1,
      RSP_ELEM = 2'd2,
      RSP_BAD  = 2'd3
   } rsp_e;

   function automatic logic dim_ok(input logic [31:0] n, input int unsigned max_n);
      return (n >= 32'd1) && (n <= max_n);
   endfunction

endpackage

// File: rtl/det_mat_ram.sv
// Element store: register array with one synchronous write port and one
// asynchronous read port.
module det_mat_ram #(
   parameter int DEPTH = 64,
   parameter int DW    = 20,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; only elements written by the current load
   // are ever read, so clearing it would cost a reset net per bit for nothing.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/det_matrix_mem.sv
// Matrix-store responder: streams a matrix in, serves the engine's header and
// element reads while it runs, and captures the engine's result.
module det_matrix_mem
   import det_pkg::*;
#(
   parameter int MAX_N = MAX_N_DEF,
   parameter int DW    = DW_DEF,
   parameter int RW    = RW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          eng_reset,
   input  logic [DW-1:0] i,
   input  logic [DW-1:0] j,
   input  logic          read,
   input  logic          write,
   input  logic [RW-1:0] write_data,
   input  logic          finish,
   output logic [DW-1:0] read_data,
   output logic [RW-1:0] result,
   output logic          result_valid,
   output logic          err
);

   localparam int DEPTH = MAX_N * MAX_N;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam int NW    = $clog2(MAX_N + 1);

   state_e          state_q, state_d;
   logic [NW-1:0]   n_q, n_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            hdr_q, hdr_d;
   logic [RW-1:0]   result_q, result_d;
   logic            result_valid_q, result_valid_d;
   logic            err_q, err_d;

   logic            beat;
   logic            in_range;
   logic            last_elem;
   logic            mem_we;
   logic [2*NW-1:0] n_ext;
   logic [2*NW-1:0] nn;
   logic [AW-1:0]   raddr;
   logic [DW-1:0]   ram_rdata;
   rsp_e            rsp;

   assign ld_ready  = (state_q != ST_RUN);
   assign eng_reset = (state_q != ST_RUN);
   assign beat      = ld_valid && ld_ready;

   assign n_ext     = (2*NW)'(n_q);
   assign nn        = n_ext * n_ext;
   assign last_elem = ((2*NW)'(cnt_q) == (nn - (2*NW)'(1)));

   // The address is only formed from the narrowed indices once both are known
   // to be below N, so i*N+j cannot wrap into a valid-looking slot.
   assign in_range = (i < DW'(n_q)) && (j < DW'(n_q));
   assign raddr    = in_range ? (AW'(i[IW-1:0]) * AW'(n_q) + AW'(j[IW-1:0])) : '0;

   det_mat_ram #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (cnt_q),
      .wdata_i (ld_data),
      .raddr_i (raddr),
      .rdata_o (ram_rdata)
   );

   // NOTE: every combinational output gets a default first so no path through
   // the if/case tree can leave it unassigned and infer a latch.
   always_comb begin
      rsp       = RSP_ZERO;
      read_data = '0;
      if (read) begin
         if (hdr_q) begin
            rsp = RSP_HDR;
         end else if (in_range) begin
            rsp = RSP_ELEM;
         end else begin
            rsp = RSP_BAD;
         end
      end
      case (rsp)
         RSP_HDR:  read_data = DW'(n_q);
         RSP_ELEM: read_data = ram_rdata;
         default:  read_data = '0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      cnt_d          = cnt_q;
      hdr_d          = hdr_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      err_d          = err_q;
      mem_we         = 1'b0;

      case (state_q)
         ST_LOAD_N, ST_DONE: begin
            if (beat) begin
               if (state_q == ST_DONE) begin
                  result_valid_d = 1'b0;
                  err_d          = 1'b0;
               end
               if (dim_ok(32'(ld_data), MAX_N)) begin
                  n_d     = NW'(ld_data);
                  cnt_d   = '0;
                  state_d = ST_LOAD_E;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_LOAD_N;
               end
            end
         end
         ST_LOAD_E: begin
            if (beat) begin
               mem_we = 1'b1;
               cnt_d  = cnt_q + AW'(1);
               if (last_elem) begin
                  state_d = ST_RUN;
                  hdr_d   = 1'b1;
               end
            end
         end
         ST_RUN: begin
            // The first read of a run is the engine's dimension fetch.
            if (read) begin
               hdr_d = 1'b0;
            end
            if (finish && write) begin
               result_d       = write_data;
               result_valid_d = 1'b1;
               hdr_d          = 1'b0;
               state_d        = ST_DONE;
            end
         end
         default: state_d = ST_LOAD_N;
      endcase

      if (rsp == RSP_BAD) begin
         err_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_LOAD_N;
         n_q            <= '0;
         cnt_q          <= '0;
         hdr_q          <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         n_q            <= n_d;
         cnt_q          <= cnt_d;
         hdr_q          <= hdr_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_q          <= err_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign err          = err_q;

endmodule

// File: tb/tb_det_matrix_mem.sv
// Directed, table-driven bench for det_matrix_mem plus hand-written sequences
// for reset in the middle of a load.
module tb_det_matrix_mem;

   logic        clk;
   logic        reset;
   logic        ld_valid;
   logic [19:0] ld_data;
   logic        ld_ready;
   logic        eng_reset;
   logic [19:0] i;
   logic [19:0] j;
   logic        read;
   logic        write;
   logic [39:0] write_data;
   logic        finish;
   logic [19:0] read_data;
   logic [39:0] result;
   logic        result_valid;
   logic        err;

   int checks = 0;
   int errors = 0;

   det_matrix_mem #(
      .MAX_N (8),
      .DW    (20),
      .RW    (40)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ld_valid     (ld_valid),
      .ld_data      (ld_data),
      .ld_ready     (ld_ready),
      .eng_reset    (eng_reset),
      .i            (i),
      .j            (j),
      .read         (read),
      .write        (write),
      .write_data   (write_data),
      .finish       (finish),
      .read_data    (read_data),
      .result       (result),
      .result_valid (result_valid),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs applied for one cycle and the outputs expected in that same cycle
   // (before the edge that consumes the inputs).
   typedef struct packed {
      logic        ldv;
      logic [19:0] ldd;
      logic        rd;
      logic [19:0] ii;
      logic [19:0] jj;
      logic        wr;
      logic        fin;
      logic [39:0] wd;
      logic [19:0] exp_rd;
      logic        exp_er;
      logic        exp_rdy;
      logic        exp_rv;
      logic        exp_err;
      logic [39:0] exp_res;
   } vec_t;

   vec_t vecs [64];
   int   nv = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic ldv, input logic [19:0] ldd, input logic rd,
                      input logic [19:0] ii, input logic [19:0] jj,
                      input logic wr, input logic fin, input logic [39:0] wd,
                      input logic [19:0] erd, input logic er, input logic rdy,
                      input logic rv, input logic e, input logic [39:0] res);
      vecs[nv] = '{ldv, ldd, rd, ii, jj, wr, fin, wd, erd, er, rdy, rv, e, res};
      nv++;
   endtask

   // Accepted load beat while the engine is held in reset.
   task automatic add_ld(input logic [19:0] d, input logic rv, input logic e, input logic [39:0] res);
      add(1'b1, d, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0, 40'd0, 20'd0, 1'b1, 1'b1, rv, e, res);
   endtask

   // Engine read while running.
   task automatic add_rd(input logic [19:0] ii, input logic [19:0] jj, input logic [19:0] erd,
                         input logic e, input logic [39:0] res);
      add(1'b0, 20'd0, 1'b1, ii, jj, 1'b0, 1'b0, 40'd0, erd, 1'b0, 1'b0, 1'b0, e, res);
   endtask

   task automatic drive_idle();
      ld_valid   = 1'b0;
      ld_data    = '0;
      read       = 1'b0;
      i          = '0;
      j          = '0;
      write      = 1'b0;
      finish     = 1'b0;
      write_data = '0;
   endtask

   task automatic check_outputs(input string tag, input logic [19:0] erd, input logic er,
                                input logic rdy, input logic rv, input logic e,
                                input logic [39:0] res);
      check({tag, " read_data"},    64'(read_data),    64'(erd));
      check({tag, " eng_reset"},    64'(eng_reset),    64'(er));
      check({tag, " ld_ready"},     64'(ld_ready),     64'(rdy));
      check({tag, " result_valid"}, 64'(result_valid), 64'(rv));
      check({tag, " err"},          64'(err),          64'(e));
      check({tag, " result"},       64'(result),       64'(res));
   endtask

   task automatic ld_beat(input logic [19:0] d);
      @(negedge clk);
      drive_idle();
      ld_valid = 1'b1;
      ld_data  = d;
   endtask

   task automatic rd_at(input logic [19:0] ii, input logic [19:0] jj);
      @(negedge clk);
      drive_idle();
      read = 1'b1;
      i    = ii;
      j    = jj;
   endtask

   initial begin
      // N=2 matrix [[1,2],[3,4]]: header, element reads, held load beat, bad read
      add_ld(20'd2, 1'b0, 1'b0, 40'd0);
      add_ld(20'd1, 1'b0, 1'b0, 40'd0);
      add_ld(20'd2, 1'b0, 1'b0, 40'd0);
      add_ld(20'd3, 1'b0, 1'b0, 40'd0);
      add_ld(20'd4, 1'b0, 1'b0, 40'd0);
      add_rd(20'd0, 20'd0, 20'd2, 1'b0, 40'd0);
      add_rd(20'd0, 20'd0, 20'd1, 1'b0, 40'd0);
      add_rd(20'd1, 20'd0, 20'd3, 1'b0, 40'd0);
      add_rd(20'd1, 20'd1, 20'd4, 1'b0, 40'd0);
      add(1'b1, 20'd9, 1'b1, 20'd0, 20'd1, 1'b0, 1'b0, 40'd0, 20'd2, 1'b0, 1'b0, 1'b0, 1'b0, 40'd0);
      add_rd(20'd2, 20'd0, 20'd0, 1'b0, 40'd0);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b1, 1'b0, 40'd5,       20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 40'd0);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 40'h12345,   20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 40'd0);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0, 40'd0,       20'd0, 1'b1, 1'b1, 1'b1, 1'b1, 40'h12345);
      // Re-arm from DONE with N=1, element 9
      add_ld(20'd1, 1'b1, 1'b1, 40'h12345);
      add_ld(20'd9, 1'b0, 1'b0, 40'h12345);
      add_rd(20'd0, 20'd0, 20'd1, 1'b0, 40'h12345);
      add_rd(20'd0, 20'd0, 20'd9, 1'b0, 40'h12345);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 40'hAB,      20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 40'h12345);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0, 40'd0,       20'd0, 1'b1, 1'b1, 1'b1, 1'b0, 40'hAB);
      // Bad dimensions 0 and 9, then N=1 with element 7
      add_ld(20'd0, 1'b1, 1'b0, 40'hAB);
      add_ld(20'd9, 1'b0, 1'b1, 40'hAB);
      add_ld(20'd1, 1'b0, 1'b1, 40'hAB);
      add_ld(20'd7, 1'b0, 1'b1, 40'hAB);
      add_rd(20'd0, 20'd0, 20'd1, 1'b1, 40'hAB);
      add_rd(20'd0, 20'd0, 20'd7, 1'b1, 40'hAB);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 40'd1,       20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 40'hAB);
      // N=3 matrix of 10..18, out-of-range reads at the edge of the matrix
      add_ld(20'd3, 1'b1, 1'b1, 40'd1);
      for (int k = 0; k < 9; k++) add_ld(20'(10 + k), 1'b0, 1'b0, 40'd1);
      add_rd(20'd0, 20'd0, 20'd3,  1'b0, 40'd1);
      add_rd(20'd3, 20'd0, 20'd0,  1'b0, 40'd1);
      add_rd(20'd2, 20'd2, 20'd18, 1'b1, 40'd1);
      add_rd(20'd0, 20'd3, 20'd0,  1'b1, 40'd1);
      add_rd(20'd1, 20'd2, 20'd15, 1'b1, 40'd1);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 40'hFF_FFFF_FFFF, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 40'd1);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0, 40'd0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b1, 40'hFF_FFFF_FFFF);
      // Finish coinciding with an out-of-range read captures both
      add_ld(20'd1, 1'b1, 1'b1, 40'hFF_FFFF_FFFF);
      add_ld(20'd5, 1'b0, 1'b0, 40'hFF_FFFF_FFFF);
      add_rd(20'd0, 20'd0, 20'd1, 1'b0, 40'hFF_FFFF_FFFF);
      add(1'b0, 20'd0, 1'b1, 20'd1, 20'd1, 1'b1, 1'b1, 40'h80_0000_0001, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 40'hFF_FFFF_FFFF);
      add(1'b0, 20'd0, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0, 40'd0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b1, 40'h80_0000_0001);

      drive_idle();
      reset = 1'b0;
      @(negedge clk);
      #1;
      check_outputs("reset", 20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 40'd0);
      reset = 1'b1;

      for (int k = 0; k < nv; k++) begin
         @(negedge clk);
         ld_valid   = vecs[k].ldv;
         ld_data    = vecs[k].ldd;
         read       = vecs[k].rd;
         i          = vecs[k].ii;
         j          = vecs[k].jj;
         write      = vecs[k].wr;
         finish     = vecs[k].fin;
         write_data = vecs[k].wd;
         #1;
         check_outputs($sformatf("v%0d", k), vecs[k].exp_rd, vecs[k].exp_er, vecs[k].exp_rdy,
                       vecs[k].exp_rv, vecs[k].exp_err, vecs[k].exp_res);
      end

      // Reset after 2 of 4 elements of an N=2 load
      ld_beat(20'd2);
      ld_beat(20'd5);
      ld_beat(20'd6);
      @(negedge clk);
      drive_idle();
      #2;
      reset = 1'b0;
      #1;
      check_outputs("midload_reset", 20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 40'd0);
      @(negedge clk);
      reset = 1'b1;

      ld_beat(20'd2);
      ld_beat(20'd5);
      ld_beat(20'd6);
      ld_beat(20'd7);
      ld_beat(20'd8);
      #1;
      check("reload last beat eng_reset", 64'(eng_reset), 64'd1);
      @(negedge clk);
      drive_idle();
      #1;
      check("reload run eng_reset", 64'(eng_reset), 64'd0);
      check("reload run ld_ready",  64'(ld_ready),  64'd0);
      rd_at(20'd0, 20'd0);
      #1;
      check("reload header", 64'(read_data), 64'd2);
      rd_at(20'd1, 20'd1);
      #1;
      check("reload (1,1)", 64'(read_data), 64'd8);
      rd_at(20'd1, 20'd0);
      #1;
      check("reload (1,0)", 64'(read_data), 64'd7);
      check("reload err", 64'(err), 64'd0);
      @(negedge clk);
      drive_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
